// File: rtl/cla_sub_pipe16.sv
// Pipelined borrow-lookahead subtractor d = a - b - bin, one 4-bit group per stage.
// Define SUB_SAT_EN to clamp d to zero whenever the subtraction borrows out.
module cla_sub_pipe16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);
    // WIDTH must be a multiple of 4 and at least 8, so there are two or more stages.
    localparam int N = WIDTH / 4;

    // Returns {group borrow out, 4 difference bits}.
    function automatic logic [4:0] grp_sub(input logic [3:0] x, input logic [3:0] y,
                                           input logic bi);
        logic [3:0] g;
        logic [3:0] p;
        logic [3:0] br;
        logic       gb;
        logic       gp;
        g     = ~x & y;
        p     = ~(x ^ y);
        br[0] = bi;
        br[1] = g[0] | (p[0] & bi);
        br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
        br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bi);
        gb    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        gp    = &p;
        return {gb | (gp & bi), x ^ y ^ br};
    endfunction

    for (genvar k = 0; k < N; k++) begin : stg
        logic                 v_q, v_d;
        logic                 brw_q, brw_d;
        logic                 ld;
        logic                 up_v;
        logic                 bi;
        logic [WIDTH-4*k-1:0] up_a;
        logic [WIDTH-4*k-1:0] up_b;
        logic [4:0]           res;

        if (k == 0) begin : head
            assign up_v = in_valid;
            assign up_a = a;
            assign up_b = b;
            assign bi   = bin;
        end else begin : body
            assign up_v = stg[k-1].v_q;
            assign up_a = stg[k-1].mid.a_rem_q;
            assign up_b = stg[k-1].mid.b_rem_q;
            assign bi   = stg[k-1].brw_q;
        end

        // A stage can load when it is empty or its content moves on this edge.
        if (k == N - 1) begin : tail_ld
            assign ld = ~v_q | out_ready;
        end else begin : chain_ld
            assign ld = ~v_q | stg[k+1].ld;
        end

        assign res = grp_sub(up_a[3:0], up_b[3:0], bi);

        // NOTE: every always_comb output gets its hold value first, so no latch is inferred.
        always_comb begin
            v_d   = v_q;
            brw_d = brw_q;
            if (ld) begin
                v_d = up_v;
                if (up_v) brw_d = res[4];
            end
        end

        // NOTE: state flops use non-blocking assignments so every stage samples pre-edge values.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q   <= 1'b0;
                brw_q <= 1'b0;
            end else begin
                v_q   <= v_d;
                brw_q <= brw_d;
            end
        end

        if (k < N - 1) begin : mid
            logic [WIDTH-4*k-5:0] a_rem_q, a_rem_d;
            logic [WIDTH-4*k-5:0] b_rem_q, b_rem_d;
            logic [4*k+3:0]       dacc_q, dacc_d;
            logic [4*k+3:0]       dacc_new;

            if (k == 0) begin : first
                assign dacc_new = res[3:0];
            end else begin : later
                assign dacc_new = {res[3:0], stg[k-1].mid.dacc_q};
            end

            always_comb begin
                a_rem_d = a_rem_q;
                b_rem_d = b_rem_q;
                dacc_d  = dacc_q;
                if (ld && up_v) begin
                    a_rem_d = up_a[WIDTH-4*k-1:4];
                    b_rem_d = up_b[WIDTH-4*k-1:4];
                    dacc_d  = dacc_new;
                end
            end

            // NOTE: payload flops carry no reset; the valid bit alone says whether they mean anything.
            always_ff @(posedge clk) begin
                a_rem_q <= a_rem_d;
                b_rem_q <= b_rem_d;
                dacc_q  <= dacc_d;
            end
        end else begin : last
            logic [WIDTH-1:0] d_q, d_d;
            logic [WIDTH-1:0] raw_diff;
            logic             ovf_q, ovf_d;

            assign raw_diff = {res[3:0], stg[k-1].mid.dacc_q};

            always_comb begin
                d_d   = d_q;
                ovf_d = ovf_q;
                if (ld && up_v) begin
`ifdef SUB_SAT_EN
                    d_d = res[4] ? '0 : raw_diff;
`else
                    d_d = raw_diff;
`endif
                    // Overflow is judged on the raw difference, before any clamping.
                    ovf_d = (up_a[3] ^ up_b[3]) & (res[3] ^ up_a[3]);
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    d_q   <= '0;
                    ovf_q <= 1'b0;
                end else begin
                    d_q   <= d_d;
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign in_ready  = ~rst & stg[0].ld;
    assign out_valid = stg[N-1].v_q;
    assign d         = stg[N-1].last.d_q;
    assign bout      = stg[N-1].brw_q;
    assign ovf       = stg[N-1].last.ovf_q;

endmodule
